i2c_config_sequencer: RTL and testbench
=======================================

Name: i2c_config_sequencer

Overview:
- Upstream feeder for the multi-byte I2C register writer in SensorModule.
- Walks a byte-coded sensor configuration table held in an external synchronous ROM; each entry is one burst register write.
- Per entry: loads the data bytes into the writer's FIFO, presents reg_address/byte_width, pulses the writer start, then waits for done or failure.
- Failed or hung transactions are retried a bounded number of times; table completion or a fatal error is reported to the top-level init controller.

Parameters:
- DEV_ADDR, 7'h29, 7-bit I2C device address driven on dev_address.
- ROM_AW, 8, config ROM address width.
- MAX_RETRIES, 3, retries allowed per entry after the first attempt.
- WAIT_TIMEOUT, 24'd2_000_000, cycles allowed from writer start until done/failure (watchdog).
- DELAY_UNIT, 16'd50_000, cycles per delay tick (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- init_start  in  1  pulse; begin table walk at ROM address 0.
- init_busy  out  1  high from accepted init_start until DONE/ERROR.
- init_done  out  1  level; table completed; cleared by next init_start.
- init_error  out  1  level; fatal error; cleared by next init_start.
- error_code  out  2  0 none, 1 retries exhausted, 2 bad header, 3 table overrun.
- error_index  out  8  entry number (0-based) active when the error occurred.
- rom_addr  out  ROM_AW  ROM read address.
- rom_data  in  8  ROM data for the rom_addr of the previous cycle (1-cycle latency).
- dev_address  out  7  constant DEV_ADDR.
- reg_address  out  8  register address of current entry.
- byte_width  out  4  data byte count of current entry.
- wr_start  out  1  one-cycle start pulse to writer.
- wr_done  in  1  writer done pulse.
- wr_failure  in  1  writer message_failure pulse.
- fifo_data  out  8  byte to writer FIFO.
- fifo_wr_en  out  1  one-cycle FIFO write strobe.
- fifo_ext_reset  out  1  writer FIFO reset.
- fifo_full  in  1  writer FIFO full.
- fifo_write_ack  in  1  FIFO write acknowledge, one cycle after fifo_wr_en.

Behaviour:
- Reset values: all outputs 0, except fifo_ext_reset = 1. fifo_ext_reset drops on the first clock in IDLE.
- Table format, per entry:
  - header byte N (1..15 = byte count; 0x00 = end of table);
  - register address byte;
  - N data bytes.
- States: IDLE, HDR, REG, DATA, PUSH, ACK, KICK, WAIT, FLUSH, DONE, ERROR (plus DELAY with the optional feature).
- IDLE: on init_start go to HDR with rom_addr = 0, entry_base = 0, entry index = 0, retry_count = 0; clear init_done, init_error and error_code. init_start is ignored in every state other than IDLE, DONE and ERROR.
- HDR: sample rom_data one cycle after issuing the address.
  - 0x00 -> DONE.
  - 1..15 -> latch byte_width and go to REG.
  - any other value -> ERROR with code 2.
- REG: latch reg_address; byte_width and reg_address then stay stable until WAIT exits.
- DATA/PUSH/ACK loop, once per byte:
  - fetch the byte from the ROM;
  - in PUSH, stall while fifo_full is high, otherwise pulse fifo_wr_en with fifo_data;
  - in ACK, require fifo_write_ack; if it is absent, take the failure path.
- KICK: after N bytes are pushed, pulse wr_start for exactly 1 cycle; watchdog counter loads 0.
- WAIT:
  - wr_done -> advance entry_base to the next header, increment entry index, clear retry_count, go to HDR.
  - wr_failure or watchdog reaching WAIT_TIMEOUT -> failure path.
  - wr_done and wr_failure in the same cycle -> treated as failure.
- Failure path (FLUSH):
  - assert fifo_ext_reset for 2 cycles and rewind rom_addr to entry_base;
  - if retry_count == MAX_RETRIES -> ERROR with code 1;
  - otherwise increment retry_count and go to HDR.
- Table overrun: if rom_addr is at 2^ROM_AW-1 and another byte is still required -> ERROR with code 3. The address never wraps.
- DONE/ERROR: init_busy = 0; status held until the next init_start.
- Asynchronous reset mid-operation: immediate return to reset values. fifo_ext_reset = 1 flushes partial data in the writer FIFO.

Optional Feature:
- Macro: CFG_DELAY_CMD_EN.
- Defined: header 0xFF is a delay command.
  - The next byte D is read, then the block waits D*DELAY_UNIT cycles in DELAY, then goes to the next header.
  - No I2C traffic is generated; entry index still increments.
  - D = 0 means no wait.
- Undefined: 0xFF is a bad header -> ERROR with code 2.

Test Plan:
- Table {02,10,AA,BB,01,20,CC,00}, writer model always done -> pushes AA,BB then wr_start with reg 0x10/width 2; then CC with reg 0x20/width 1; init_done=1, init_error=0.
- Writer model asserts wr_failure twice on entry 0, then done -> fifo_ext_reset pulses twice, bytes re-pushed each time, init_done=1.
- wr_failure on every attempt, MAX_RETRIES=3 -> exactly 4 wr_start pulses, then init_error=1, error_code=1, error_index=0.
- No response after wr_start, WAIT_TIMEOUT=100 -> failure path at cycle 100, retry observed.
- Header 0x13 -> error_code=2. ROM with no 0x00 terminator -> error_code=3, rom_addr never exceeds 0xFF.
- fifo_full held 10 cycles during PUSH -> no fifo_wr_en while full. Reset asserted mid-PUSH -> fifo_ext_reset=1, all other outputs 0.

Source files
------------

// File: rtl/i2c_config_sequencer.sv
// Walks a byte-coded config table in ROM and feeds a burst I2C register writer.
// Define CFG_DELAY_CMD_EN to treat header 0xFF as a delay command.
module i2c_config_sequencer #(
  parameter logic [6:0]  DEV_ADDR     = 7'h29,
  parameter int          ROM_AW       = 8,
  parameter int          MAX_RETRIES  = 3,
  parameter logic [23:0] WAIT_TIMEOUT = 24'd2_000_000,
  parameter logic [15:0] DELAY_UNIT   = 16'd50_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              init_error,
  output logic [1:0]        error_code,
  output logic [7:0]        error_index,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [6:0]        dev_address,
  output logic [7:0]        reg_address,
  output logic [3:0]        byte_width,
  output logic              wr_start,
  input  logic              wr_done,
  input  logic              wr_failure,
  output logic [7:0]        fifo_data,
  output logic              fifo_wr_en,
  output logic              fifo_ext_reset,
  input  logic              fifo_full,
  input  logic              fifo_write_ack
);

  typedef enum logic [3:0] {
    IDLE, HDR, REG, DATA, PUSH, ACK,
    KICK, WAIT, FLUSH, DONE, ERROR
`ifdef CFG_DELAY_CMD_EN
    , DELAY
`endif
  } state_t;

  state_t state_q, state_d;
  logic [1:0] code_d;

  logic              phase_q;
  logic [ROM_AW-1:0] addr_q, base_q;
  logic [7:0]        idx_q, retry_q;
  logic [23:0]       wdog_q;
  logic [3:0]        left_q, width_q;
  logic [7:0]        reg_q, data_q;
  logic [1:0]        code_q;
  logic [7:0]        eidx_q;
  logic              frst_q;
  logic [6:0]        dev_q;
`ifdef CFG_DELAY_CMD_EN
  logic              dly_q;
  logic [7:0]        tick_q;
  logic [15:0]       unit_q;
`endif

  logic at_end, hdr_ok, wd_exp;
  logic rd_st, start_ok, adv, next_ent;

  assign at_end   = addr_q == {ROM_AW{1'b1}};
  assign wd_exp   = wdog_q == WAIT_TIMEOUT - 24'd1;
  assign rd_st    = state_q inside {HDR, REG, DATA, FLUSH};
  assign start_ok = init_start
                 && (state_q inside {IDLE, DONE, ERROR});
`ifdef CFG_DELAY_CMD_EN
  assign hdr_ok   = rom_data[7:4] == 4'h0
                 || rom_data == 8'hFF;
  assign next_ent = state_d == HDR
                 && (state_q == WAIT || state_q == DELAY);
`else
  assign hdr_ok   = rom_data[7:4] == 4'h0;
  assign next_ent = state_d == HDR && state_q == WAIT;
`endif
  assign adv = (state_q == HDR && state_d == REG)
            || (state_q == REG && state_d == DATA)
            || (state_q == ACK && state_d == DATA)
            || next_ent;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    code_d  = 2'd0;
    unique case (state_q)
      IDLE, DONE, ERROR: if (start_ok) state_d = HDR;
      HDR: if (phase_q) begin
        if (rom_data == 8'h00) state_d = DONE;
        else if (!hdr_ok) begin
          state_d = ERROR;
          code_d  = 2'd2;
        end else if (at_end) begin
          state_d = ERROR;
          code_d  = 2'd3;
        end else state_d = REG;
      end
      REG: if (phase_q) begin
`ifdef CFG_DELAY_CMD_EN
        if (dly_q) state_d = DELAY;
        else
`endif
        if (at_end) begin
          state_d = ERROR;
          code_d  = 2'd3;
        end else state_d = DATA;
      end
      DATA: if (phase_q) state_d = PUSH;
      PUSH: if (!fifo_full) state_d = ACK;
      ACK: begin
        if (!fifo_write_ack) state_d = FLUSH;
        else if (left_q == 4'd1) state_d = KICK;
        else if (at_end) begin
          state_d = ERROR;
          code_d  = 2'd3;
        end else state_d = DATA;
      end
      KICK: state_d = WAIT;
      // a simultaneous done+failure counts as a failure
      WAIT: begin
        if (wr_failure || wd_exp) state_d = FLUSH;
        else if (wr_done) begin
          if (at_end) begin
            state_d = ERROR;
            code_d  = 2'd3;
          end else state_d = HDR;
        end
      end
      FLUSH: if (phase_q) begin
        if (retry_q == 8'(MAX_RETRIES)) begin
          state_d = ERROR;
          code_d  = 2'd1;
        end else state_d = HDR;
      end
`ifdef CFG_DELAY_CMD_EN
      DELAY: if (tick_q == 8'd0) begin
        if (at_end) begin
          state_d = ERROR;
          code_d  = 2'd3;
        end else state_d = HDR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      addr_q  <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      wdog_q  <= '0;
      left_q  <= '0;
      width_q <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      code_q  <= '0;
      eidx_q  <= '0;
      frst_q  <= 1'b1;
      dev_q   <= '0;
`ifdef CFG_DELAY_CMD_EN
      dly_q   <= 1'b0;
      tick_q  <= '0;
      unit_q  <= '0;
`endif
    end else begin
      dev_q   <= DEV_ADDR;
      phase_q <= rd_st && state_d == state_q;
      if (state_q == IDLE) frst_q <= 1'b0;

      if (start_ok) begin
        addr_q  <= '0;
        base_q  <= '0;
        idx_q   <= '0;
        retry_q <= '0;
        code_q  <= '0;
      end else if (state_q == FLUSH) begin
        addr_q <= base_q;
      end else if (adv) begin
        addr_q <= addr_q + 1'b1;
      end

      if (next_ent) begin
        base_q  <= addr_q + 1'b1;
        idx_q   <= idx_q + 8'd1;
        retry_q <= '0;
      end
      if (state_q == FLUSH && state_d == HDR)
        retry_q <= retry_q + 8'd1;

      if (state_d == ERROR && state_q != ERROR) begin
        code_q <= code_d;
        eidx_q <= idx_q;
      end

      if (state_q == HDR && state_d == REG) begin
        left_q <= rom_data[3:0];
        if (rom_data[7:4] == 4'h0) width_q <= rom_data[3:0];
`ifdef CFG_DELAY_CMD_EN
        dly_q <= &rom_data;
`endif
      end

      if (state_q == REG && phase_q) begin
`ifdef CFG_DELAY_CMD_EN
        tick_q <= rom_data;
        unit_q <= '0;
        if (!dly_q) reg_q <= rom_data;
`else
        reg_q <= rom_data;
`endif
      end

      if (state_q == DATA && phase_q) data_q <= rom_data;
      if (state_q == ACK && fifo_write_ack) left_q <= left_q - 4'd1;

      if (state_q == KICK)      wdog_q <= '0;
      else if (state_q == WAIT) wdog_q <= wdog_q + 24'd1;

`ifdef CFG_DELAY_CMD_EN
      if (state_q == DELAY && tick_q != 8'd0) begin
        if (unit_q == DELAY_UNIT - 16'd1) begin
          unit_q <= '0;
          tick_q <= tick_q - 8'd1;
        end else unit_q <= unit_q + 16'd1;
      end
`endif
    end
  end

  always_comb begin
    init_busy      = 1'b1;
    init_done      = 1'b0;
    init_error     = 1'b0;
    wr_start       = 1'b0;
    fifo_wr_en     = 1'b0;
    fifo_ext_reset = frst_q;
    unique case (state_q)
      IDLE: init_busy = 1'b0;
      DONE: begin
        init_busy = 1'b0;
        init_done = 1'b1;
      end
      ERROR: begin
        init_busy  = 1'b0;
        init_error = 1'b1;
      end
      PUSH:  fifo_wr_en     = !fifo_full;
      KICK:  wr_start       = 1'b1;
      FLUSH: fifo_ext_reset = 1'b1;
      default: ;
    endcase
  end

  assign error_code  = code_q;
  assign error_index = eidx_q;
  assign rom_addr    = addr_q;
  assign dev_address = dev_q;
  assign reg_address = reg_q;
  assign byte_width  = width_q;
  assign fifo_data   = data_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Scoreboard bench for i2c_config_sequencer: ROM, FIFO-ack and writer models
// plus a negedge monitor that pops expected pushes/starts.
module tb_i2c_config_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_start = 1'b0;
  logic       fifo_full = 1'b0;
  logic       init_busy, init_done, init_error;
  logic [1:0] error_code;
  logic [7:0] error_index, rom_addr, rom_data;
  logic [6:0] dev_address;
  logic [7:0] reg_address, fifo_data;
  logic [3:0] byte_width;
  logic       wr_start, wr_done, wr_failure;
  logic       fifo_wr_en, fifo_ext_reset, fifo_write_ack;

  i2c_config_sequencer #(.WAIT_TIMEOUT(24'd100)) dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done),
    .init_error(init_error), .error_code(error_code),
    .error_index(error_index), .rom_addr(rom_addr),
    .rom_data(rom_data), .dev_address(dev_address),
    .reg_address(reg_address), .byte_width(byte_width),
    .wr_start(wr_start), .wr_done(wr_done),
    .wr_failure(wr_failure), .fifo_data(fifo_data),
    .fifo_wr_en(fifo_wr_en), .fifo_ext_reset(fifo_ext_reset),
    .fifo_full(fifo_full), .fifo_write_ack(fifo_write_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         st;
    logic [7:0] a;
    logic [3:0] w;
  } ev_t;
  typedef logic [7:0] tbl_t[$];

  ev_t  exp_q[$];
  int   resp_plan[$];
  bit   ack_plan[$];
  logic [7:0] rom [256];
  tbl_t tbl;

  int n_total = 0;
  int n_pass  = 0;
  int viol = 0, fer_rises = 0, cyc = 0, st_cyc = 0;
  int fer_delta = 0;
  logic fer_prev = 1'b1;
  int base_r, base_v;

  // 1-cycle latency config ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin : ack_model
    bit drop;
    fifo_write_ack <= 1'b0;
    if (fifo_wr_en) begin
      drop = ack_plan.size() != 0 ? ack_plan.pop_front() : 1'b0;
      fifo_write_ack <= !drop;
    end
  end

  // plan codes: 0 done, 1 failure, 2 no response
  always @(posedge clk) begin : writer_model
    int wcnt, wkind;
    wr_done    <= 1'b0;
    wr_failure <= 1'b0;
    if (wcnt > 0) begin
      wcnt = wcnt - 1;
      if (wcnt == 0 && wkind == 0) wr_done <= 1'b1;
      if (wcnt == 0 && wkind == 1) wr_failure <= 1'b1;
    end
    if (wr_start) begin
      wkind = resp_plan.size() != 0 ? resp_plan.pop_front() : 0;
      wcnt  = 3;
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic sb_check(input bit st, input logic [7:0] a,
                          input logic [3:0] w);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_unexpected: got st=%0d a=%h w=%0d, required none",
               st, a, w);
      return;
    end
    e = exp_q.pop_front();
    if (e.st == st && e.a === a && (!st || e.w === w)) n_pass++;
    else $display("FAIL sb_event: got st=%0d a=%h w=%0d, required st=%0d a=%h w=%0d",
                  st, a, w, e.st, e.a, e.w);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (fifo_wr_en) begin
        if (fifo_full) viol++;
        sb_check(1'b0, fifo_data, 4'd0);
      end
      if (wr_start) begin
        st_cyc = cyc;
        sb_check(1'b1, reg_address, byte_width);
      end
      if (fifo_ext_reset && !fer_prev) begin
        fer_rises++;
        fer_delta = cyc - st_cyc;
      end
    end
    fer_prev = fifo_ext_reset;
  end

  task automatic ex_push(input logic [7:0] b);
    exp_q.push_back('{1'b0, b, 4'd0});
  endtask

  task automatic ex_start(input logic [7:0] a, input logic [3:0] w);
    exp_q.push_back('{1'b1, a, w});
  endtask

  task automatic load(input tbl_t t);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    for (int i = 0; i < t.size(); i++) rom[i] = t[i];
    base_r = fer_rises;
    base_v = viol;
  endtask

  task automatic kick();
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    chk("busy_after_start", init_busy, 1);
    chk("status_cleared", {init_done, init_error, error_code}, 0);
  endtask

  task automatic wait_end(input int maxc);
    int c = 0;
    while (init_busy && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("finish_in_budget", init_busy, 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_fifo_ext_reset", fifo_ext_reset, 1);
    chk("rst_outputs", {init_busy, init_done, init_error,
        error_code, error_index, rom_addr, dev_address,
        reg_address, byte_width, wr_start, fifo_data,
        fifo_wr_en}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_fifo_ext_reset", fifo_ext_reset, 0);
    chk("dev_address", dev_address, 7'h29);

    // two entries, writer always done
    tbl = '{8'h02, 8'h10, 8'hAA, 8'hBB, 8'h01, 8'h20, 8'hCC, 8'h00};
    load(tbl);
    ex_push(8'hAA); ex_push(8'hBB); ex_start(8'h10, 4'd2);
    ex_push(8'hCC); ex_start(8'h20, 4'd1);
    kick();
    wait_end(2000);
    chk("t1_done", {init_done, init_error}, 2'b10);
    chk("t1_no_flush", fer_rises - base_r, 0);

    // two failures then done
    tbl = '{8'h02, 8'h10, 8'hAA, 8'hBB, 8'h00};
    load(tbl);
    resp_plan = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      ex_push(8'hAA); ex_push(8'hBB); ex_start(8'h10, 4'd2);
    end
    kick();
    wait_end(2000);
    chk("t2_done", {init_done, init_error}, 2'b10);
    chk("t2_flushes", fer_rises - base_r, 2);

    // retries exhausted
    tbl = '{8'h01, 8'h30, 8'h5A, 8'h00};
    load(tbl);
    resp_plan = '{1, 1, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      ex_push(8'h5A); ex_start(8'h30, 4'd1);
    end
    kick();
    wait_end(2000);
    chk("t3_error", {init_done, init_error}, 2'b01);
    chk("t3_code", error_code, 1);
    chk("t3_index", error_index, 0);
    chk("t3_flushes", fer_rises - base_r, 4);
    resp_plan.delete();

    // watchdog timeout then success
    tbl = '{8'h01, 8'h40, 8'h77, 8'h00};
    load(tbl);
    resp_plan = '{2, 0};
    for (int i = 0; i < 2; i++) begin
      ex_push(8'h77); ex_start(8'h40, 4'd1);
    end
    kick();
    wait_end(2000);
    chk("t4_done", init_done, 1);
    chk("t4_flushes", fer_rises - base_r, 1);
    chk("t4_timeout_cycles", fer_delta, 101);

    // bad header on entry 1
    tbl = '{8'h01, 8'h10, 8'h77, 8'h13};
    load(tbl);
    ex_push(8'h77); ex_start(8'h10, 4'd1);
    kick();
    wait_end(2000);
    chk("t5_error", init_error, 1);
    chk("t5_code", error_code, 2);
    chk("t5_index", error_index, 1);

`ifndef CFG_DELAY_CMD_EN
    tbl = '{8'hFF, 8'h00};
    load(tbl);
    kick();
    wait_end(200);
    chk("t5b_code", error_code, 2);
    chk("t5b_index", error_index, 0);
`endif

    // missing FIFO ack retries the entry
    tbl = '{8'h01, 8'h60, 8'h77, 8'h00};
    load(tbl);
    ack_plan = '{1'b1};
    ex_push(8'h77); ex_push(8'h77); ex_start(8'h60, 4'd1);
    kick();
    wait_end(2000);
    chk("t6_done", init_done, 1);
    chk("t6_flushes", fer_rises - base_r, 1);

    // table overrun: 85 entries then a header at 0xFF
    tbl = '{};
    load(tbl);
    for (int i = 0; i < 85; i++) begin
      rom[3*i]   = 8'h01;
      rom[3*i+1] = 8'h00;
      rom[3*i+2] = 8'h55;
      ex_push(8'h55); ex_start(8'h00, 4'd1);
    end
    rom[255] = 8'h01;
    kick();
    wait_end(5000);
    chk("t7_code", error_code, 3);
    chk("t7_index", error_index, 85);
    chk("t7_rom_addr", rom_addr, 8'hFF);

    // fifo_full stall
    tbl = '{8'h01, 8'h50, 8'h66, 8'h00};
    load(tbl);
    ex_push(8'h66); ex_start(8'h50, 4'd1);
    fifo_full = 1'b1;
    kick();
    repeat (16) @(negedge clk);
    chk("t8_stalled", exp_q.size(), 2);
    fifo_full = 1'b0;
    wait_end(2000);
    chk("t8_no_write_when_full", viol - base_v, 0);
    chk("t8_done", init_done, 1);

    // async reset mid-PUSH
    tbl = '{8'h01, 8'h10, 8'hAA, 8'h00};
    load(tbl);
    fifo_full = 1'b1;
    kick();
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t9_fifo_ext_reset", fifo_ext_reset, 1);
    chk("t9_outputs", {init_busy, init_done, init_error,
        error_code, error_index, rom_addr, dev_address,
        reg_address, byte_width, wr_start, fifo_data,
        fifo_wr_en}, 0);
    fifo_full = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t9_idle", {init_busy, fifo_ext_reset}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
